// File: rtl/window_scheduler_if.sv
// Character stream, start-PC override channel and mesh window bundle seen by window_scheduler.
// master = scheduler side, slave = character source plus engine mesh.
interface window_scheduler_if #(
    parameter int CHARACTER_WIDTH = 8,
    parameter int CC_ID_BITS      = 1,
    parameter int PC_WIDTH        = 8
);
    localparam int W = 1 << CC_ID_BITS;

    logic                            char_valid;
    logic [CHARACTER_WIDTH-1:0]      char_data;
    logic                            char_last;
    logic                            char_ready;

    logic                            any_bb_accept;
    logic [W-1:0]                    elaborating_chars;
    logic [W*CHARACTER_WIDTH-1:0]    cur_window;
    logic [W-1:0]                    cur_window_enable;
    logic [W-1:0]                    cur_window_end_of_s;
    logic                            new_char;

    logic                            override_valid;
    logic [PC_WIDTH+CC_ID_BITS-1:0]  override_data;
    logic                            override_ready;

    modport master (
        input  char_valid, char_data, char_last,
        input  any_bb_accept, elaborating_chars, override_ready,
        output char_ready, cur_window, cur_window_enable, cur_window_end_of_s,
        output new_char, override_valid, override_data
    );

    modport slave (
        output char_valid, char_data, char_last,
        output any_bb_accept, elaborating_chars, override_ready,
        input  char_ready, cur_window, cur_window_enable, cur_window_end_of_s,
        input  new_char, override_valid, override_data
    );
endinterface

// File: rtl/window_scheduler.sv
// Streams characters into a circular window of 2**CC_ID_BITS slots, injects the start PC per
// loaded slot, retires the oldest idle slot, and ends on acceptance or end-of-string retirement.
module window_scheduler #(
    parameter int CHARACTER_WIDTH = 8,
    parameter int CC_ID_BITS      = 1,
    parameter int PC_WIDTH        = 8,
    parameter int START_PC        = 0,
    parameter int SETTLE_CYCLES   = 2,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    window_scheduler_if.master     bus,
    output logic                   done,
    output logic                   accepted,
    output logic [COUNT_WIDTH-1:0] chars_consumed
);
    localparam int W  = 1 << CC_ID_BITS;
    localparam int CW = CHARACTER_WIDTH;
    localparam int GW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    localparam logic [GW-1:0]          SETTLE   = GW'(SETTLE_CYCLES);
    localparam logic [GW-1:0]          GUARD_1  = GW'(1);
    localparam logic [CC_ID_BITS-1:0]  ID_1     = CC_ID_BITS'(1);
    localparam logic [CC_ID_BITS:0]    CNT_1    = (CC_ID_BITS + 1)'(1);
    localparam logic [CC_ID_BITS:0]    FULL     = (CC_ID_BITS + 1)'(W);
    localparam logic [PC_WIDTH-1:0]    PC0      = PC_WIDTH'(START_PC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_INJECT,
        ST_DONE
    } state_t;

    state_t                  state, state_nxt;

    logic [CC_ID_BITS-1:0]   head, tail, inj_id;
    logic [CC_ID_BITS:0]     count;
    logic [GW-1:0]           guard;
    logic [W*CW-1:0]         win_data;
    logic [W-1:0]            win_en, win_eos;
    logic                    eos_loaded;
    logic                    new_char_q;
    logic                    acc_q;
    logic [COUNT_WIDTH-1:0]  consumed;

    logic                    retire_ok, load_ok;
    logic                    clear_run, retire_fire, load_fire, inj_hs;
    logic                    guard_dec, go_done, done_acc;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

    // Guard keeps the oldest slot alive until the mesh busy flags catch up with the last change.
    assign retire_ok = (count != '0) && (guard == '0) && !bus.elaborating_chars[head];
    assign load_ok   = (count < FULL) && !eos_loaded && bus.char_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clear_run   = 1'b0;
        retire_fire = 1'b0;
        load_fire   = 1'b0;
        inj_hs      = 1'b0;
        guard_dec   = 1'b0;
        go_done     = 1'b0;
        done_acc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    clear_run = 1'b1;
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (bus.any_bb_accept) begin
                    go_done   = 1'b1;
                    done_acc  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (retire_ok) begin
                    retire_fire = 1'b1;
                    if (win_eos[head]) begin
                        go_done   = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end else if (load_ok) begin
                    load_fire = 1'b1;
                    state_nxt = ST_INJECT;
                end else begin
                    guard_dec = 1'b1;
                end
            end
            ST_INJECT: begin
                if (bus.any_bb_accept) begin
                    go_done   = 1'b1;
                    done_acc  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (bus.override_ready) begin
                    inj_hs    = 1'b1;
                    state_nxt = ST_FILL;
                end
            end
            ST_DONE: begin
                if (start) begin
                    clear_run = 1'b1;
                    state_nxt = ST_FILL;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            inj_id     <= '0;
            count      <= '0;
            guard      <= '0;
            win_data   <= '0;
            win_en     <= '0;
            win_eos    <= '0;
            eos_loaded <= 1'b0;
            new_char_q <= 1'b0;
            acc_q      <= 1'b0;
            consumed   <= '0;
        end else begin
            new_char_q <= retire_fire | inj_hs;
            if (clear_run) begin
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                guard      <= '0;
                win_data   <= '0;
                win_en     <= '0;
                win_eos    <= '0;
                eos_loaded <= 1'b0;
                acc_q      <= 1'b0;
                consumed   <= '0;
            end
            if (retire_fire) begin
                win_en[head] <= 1'b0;
                head         <= head + ID_1;
                count        <= count - CNT_1;
                guard        <= SETTLE;
            end
            if (load_fire) begin
                win_data[int'(tail)*CW +: CW] <= bus.char_data;
                win_en[tail]  <= 1'b1;
                win_eos[tail] <= bus.char_last;
                eos_loaded    <= eos_loaded | bus.char_last;
                count         <= count + CNT_1;
                consumed      <= sat_inc(consumed);
                inj_id        <= tail;
                tail          <= tail + ID_1;
            end
            if (inj_hs) begin
                guard <= SETTLE;
            end
            if (guard_dec && (guard != '0)) begin
                guard <= guard - GUARD_1;
            end
            if (go_done) begin
                win_en <= '0;
                acc_q  <= done_acc;
            end
        end
    end

    assign bus.char_ready          = load_fire;
    assign bus.override_valid      = (state == ST_INJECT);
    assign bus.override_data       = (state == ST_INJECT) ? {inj_id, PC0} : '0;
    assign bus.cur_window          = win_data;
    assign bus.cur_window_enable   = win_en;
    assign bus.cur_window_end_of_s = win_eos;
    assign bus.new_char            = new_char_q;
    assign done                    = (state == ST_DONE);
    assign accepted                = (state == ST_DONE) && acc_q;
    assign chars_consumed          = consumed;
endmodule

// File: tb/tb_window_scheduler.sv
// Directed bench for window_scheduler: stimulus queues expected injections and run results,
// a negedge monitor pops and compares them whenever the DUT presents a handshake or finishes.
module tb_window_scheduler;
    localparam int CW   = 8;
    localparam int CCB  = 1;
    localparam int PCW  = 8;
    localparam int CNTW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            done, accepted;
    logic [CNTW-1:0] chars_consumed;

    window_scheduler_if #(.CHARACTER_WIDTH(CW), .CC_ID_BITS(CCB), .PC_WIDTH(PCW)) bus ();

    window_scheduler #(
        .CHARACTER_WIDTH(CW), .CC_ID_BITS(CCB), .PC_WIDTH(PCW),
        .START_PC(0), .SETTLE_CYCLES(2), .COUNT_WIDTH(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .done(done), .accepted(accepted), .chars_consumed(chars_consumed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            acc;
        logic [CNTW-1:0] cnt;
    } done_t;

    logic [PCW+CCB-1:0] exp_inj[$];
    done_t              exp_done[$];
    logic [7:0]         chars[$];
    logic               lasts[$];
    int                 ci = 0;
    int                 checks = 0;
    int                 errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor
    logic               done_d = 1'b0;
    logic               nc_d = 1'b0;
    logic [PCW+CCB-1:0] e_inj;
    done_t              e_done;

    always @(negedge clk) begin
        if (rst) begin
            done_d = 1'b0;
            nc_d   = 1'b0;
        end else begin
            if (bus.override_valid && bus.override_ready) begin
                if (exp_inj.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_injection: got 0x%0h, expected none", bus.override_data);
                end else begin
                    e_inj = exp_inj.pop_front();
                    chk("inject_data", 64'(bus.override_data), 64'(e_inj));
                end
            end
            if (done && !done_d) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got accepted=%0d, expected no completion", accepted);
                end else begin
                    e_done = exp_done.pop_front();
                    chk("done_accepted", 64'(accepted), 64'(e_done.acc));
                    chk("done_consumed", 64'(chars_consumed), 64'(e_done.cnt));
                end
            end
            if (bus.new_char) chk("new_char_spacing", 64'(nc_d), 64'h0);
            done_d = done;
            nc_d   = bus.new_char;
        end
    end

    task automatic present();
        if (ci < chars.size()) begin
            bus.char_valid = 1'b1;
            bus.char_data  = chars[ci];
            bus.char_last  = lasts[ci];
        end else begin
            bus.char_valid = 1'b0;
            bus.char_data  = '0;
            bus.char_last  = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (bus.char_ready) ci++;
        @(posedge clk);
        #1;
        present();
    endtask

    task automatic wait_loads(input int n, input int max_cycles);
        int k = 0;
        while (ci < n && k < max_cycles) begin
            step();
            k++;
        end
        chk("loads_reached", 64'(ci), 64'(n));
    endtask

    task automatic wait_done(input int max_cycles);
        int k = 0;
        while (!done && k < max_cycles) begin
            step();
            k++;
        end
        chk("done_reached", 64'(done), 64'h1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_done"},        64'(done),                    64'h0);
        chk({tag, "_accepted"},    64'(accepted),                64'h0);
        chk({tag, "_char_ready"},  64'(bus.char_ready),          64'h0);
        chk({tag, "_ovr_valid"},   64'(bus.override_valid),      64'h0);
        chk({tag, "_ovr_data"},    64'(bus.override_data),       64'h0);
        chk({tag, "_new_char"},    64'(bus.new_char),            64'h0);
        chk({tag, "_window"},      64'(bus.cur_window),          64'h0);
        chk({tag, "_enable"},      64'(bus.cur_window_enable),   64'h0);
        chk({tag, "_end_of_s"},    64'(bus.cur_window_end_of_s), 64'h0);
        chk({tag, "_consumed"},    64'(chars_consumed),          64'h0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.char_valid        = 1'b0;
        bus.char_data         = '0;
        bus.char_last         = 1'b0;
        bus.any_bb_accept     = 1'b0;
        bus.elaborating_chars = '0;
        bus.override_ready    = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Test 1: "ab" + terminator, slots 0,1,0, ends unaccepted with 3 consumed
        chars = '{8'h61, 8'h62, 8'h0a};
        lasts = '{1'b0, 1'b0, 1'b1};
        ci = 0;
        present();
        exp_inj.push_back(9'h000);
        exp_inj.push_back(9'h100);
        exp_inj.push_back(9'h000);
        exp_done.push_back(done_t'{1'b0, 16'd3});
        pulse_start();
        wait_done(100);
        chk("t1_enables_cleared", 64'(bus.cur_window_enable), 64'h0);
        chk("t1_consumed", 64'(chars_consumed), 64'd3);

        // Test 2: acceptance in FILL after the second load
        chars = '{8'h63, 8'h64, 8'h65, 8'h66};
        lasts = '{1'b0, 1'b0, 1'b0, 1'b0};
        ci = 0;
        present();
        exp_inj.push_back(9'h000);
        exp_inj.push_back(9'h100);
        pulse_start();
        chk("t2_restart_done", 64'(done), 64'h0);
        chk("t2_restart_consumed", 64'(chars_consumed), 64'h0);
        wait_loads(2, 30);
        chk("t2_inject_second", 64'(bus.override_valid), 64'h1);
        step();
        bus.any_bb_accept = 1'b1;
        exp_done.push_back(done_t'{1'b1, 16'd2});
        @(negedge clk);
        chk("t2_no_load_on_accept", 64'(bus.char_ready), 64'h0);
        @(posedge clk);
        #1;
        bus.any_bb_accept = 1'b0;
        chk("t2_done", 64'(done), 64'h1);
        chk("t2_accepted", 64'(accepted), 64'h1);
        repeat (3) begin
            @(negedge clk);
            chk("t2_ready_low_in_done", 64'(bus.char_ready), 64'h0);
            chk("t2_accepted_held", 64'(accepted), 64'h1);
        end
        @(posedge clk);
        #1;

        // Test 3: busy mesh stalls the window at two slots
        chars = '{8'h67, 8'h68, 8'h69, 8'h6a};
        lasts = '{1'b0, 1'b0, 1'b0, 1'b0};
        ci = 0;
        present();
        bus.elaborating_chars = 2'b11;
        exp_inj.push_back(9'h000);
        exp_inj.push_back(9'h100);
        pulse_start();
        chk("t3_restart_done", 64'(done), 64'h0);
        chk("t3_restart_accepted", 64'(accepted), 64'h0);
        chk("t3_restart_consumed", 64'(chars_consumed), 64'h0);
        wait_loads(2, 30);
        repeat (8) begin
            @(negedge clk);
            chk("t3_stall_no_ready", 64'(bus.char_ready), 64'h0);
            @(posedge clk);
            #1;
        end
        chk("t3_stall_loads", 64'(ci), 64'd2);
        chk("t3_stall_enables", 64'(bus.cur_window_enable), 64'h3);
        bus.override_ready    = 1'b0;
        bus.elaborating_chars = 2'b10;
        wait_loads(3, 30);
        chk("t3_slot0_reloaded", 64'(bus.cur_window[7:0]), 64'h69);
        chk("t3_slot1_kept", 64'(bus.cur_window[15:8]), 64'h68);
        chk("t3_enables", 64'(bus.cur_window_enable), 64'h3);
        chk("t3_third_to_slot0", 64'(bus.override_data), 64'h000);

        // Test 4: override held without ready
        repeat (5) begin
            @(negedge clk);
            chk("t4_valid_held", 64'(bus.override_valid), 64'h1);
            chk("t4_data_held", 64'(bus.override_data), 64'h000);
            chk("t4_no_new_char", 64'(bus.new_char), 64'h0);
            chk("t4_no_load", 64'(bus.char_ready), 64'h0);
            @(posedge clk);
            #1;
        end

        // Test 5: asynchronous reset during INJECT
        #2;
        rst = 1'b1;
        #1;
        chk("t5_ovr_valid_async", 64'(bus.override_valid), 64'h0);
        check_zero("t5_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.elaborating_chars = '0;
        bus.override_ready    = 1'b1;
        chars = '{8'h6b, 8'h6c, 8'h0a};
        lasts = '{1'b0, 1'b0, 1'b1};
        ci = 0;
        present();
        @(negedge clk);
        check_zero("t5_idle");
        @(posedge clk);
        #1;

        // Test 6: start ignored in FILL, then restart after done
        exp_inj.push_back(9'h000);
        exp_inj.push_back(9'h100);
        exp_inj.push_back(9'h000);
        exp_done.push_back(done_t'{1'b0, 16'd3});
        pulse_start();
        wait_loads(1, 20);
        step();
        pulse_start();
        chk("t6_start_ignored_consumed", 64'(chars_consumed), 64'd2);
        chk("t6_start_ignored_done", 64'(done), 64'h0);
        wait_done(100);
        chk("t6_enables_cleared", 64'(bus.cur_window_enable), 64'h0);
        chars.delete();
        lasts.delete();
        ci = 0;
        present();
        pulse_start();
        chk("t6_restart_done", 64'(done), 64'h0);
        chk("t6_restart_accepted", 64'(accepted), 64'h0);
        chk("t6_restart_consumed", 64'(chars_consumed), 64'h0);

        repeat (2) step();
        chk("queues_drained", 64'(exp_inj.size() + exp_done.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/window_scheduler.md
Name: window_scheduler

Overview:
- Sequencing controller for the engine mesh. It streams input characters into the 2**CC_ID_BITS circular character-window slots (cur_window / cur_window_enable / cur_window_end_of_s).
- For every loaded slot it injects the start PC, tagged with that slot's CC id, through the mesh override channel.
- It retires the oldest slot once no engine still elaborates it, and ends the run on the first acceptance or on retirement of the end-of-string slot.

Parameters:
CHARACTER_WIDTH 8 bits per character
CC_ID_BITS 1 log2 of window slots (W = 2**CC_ID_BITS)
PC_WIDTH 8 PC width in override data
START_PC 0 PC injected for each new slot
SETTLE_CYCLES 2 cycles retire is blocked after any window change (min 1)
COUNT_WIDTH 16 width of consumed-character counter

Ports:
clk input 1 clock
rst input 1 reset, asynchronous, active-high
start input 1 pulse: begin a new string (ignored unless IDLE or DONE)
char_valid input 1 input character available
char_data input CHARACTER_WIDTH input character
char_last input 1 this character is the end-of-string terminator
char_ready output 1 character consumed this cycle
any_bb_accept input 1 mesh acceptance
elaborating_chars input W per-slot busy from mesh
cur_window output W*CHARACTER_WIDTH slot s at bits [s*CW +: CW]
cur_window_enable output W slot valid
cur_window_end_of_s output W slot holds terminator
new_char output 1 one-cycle pulse: window contents changed
override_valid output 1 PC injection valid
override_data output PC_WIDTH+CC_ID_BITS {slot id (MSBs), START_PC (LSBs)}
override_ready input 1 mesh took injection
done output 1 level, run finished
accepted output 1 valid with done: 1 = match
chars_consumed output COUNT_WIDTH characters loaded this run, saturating

Behaviour:
- Reset (async) and IDLE: every output is 0, and head = tail = count = 0.
- State IDLE, on start: clear slots, head, tail, count, guard and chars_consumed, then go to FILL.
- State FILL, one action per cycle, evaluated in this priority order:
  1. any_bb_accept = 1: go to DONE with accepted = 1.
  2. Retire is eligible when count > 0, guard = 0 and elaborating_chars[head] = 0. On retire: enable[head] <= 0, head++ (mod W), count--, new_char pulses next cycle, guard <= SETTLE_CYCLES. If the retired slot had end_of_s = 1, go to DONE with accepted = 0.
  3. Load is eligible when count < W, the terminator has not yet been loaded, and char_valid = 1. On load: char_ready = 1 combinationally in that cycle; slot tail gets char_data, enable = 1 and end_of_s = char_last; count++; chars_consumed++ (saturating); go to INJECT with inj_id = tail; tail++.
  4. Otherwise: guard decrements toward 0.
- State INJECT:
  - override_valid = 1 and override_data = {inj_id, START_PC}; both are held stable until override_ready.
  - On handshake: new_char pulses next cycle, guard <= SETTLE_CYCLES, return to FILL.
  - any_bb_accept = 1 in INJECT goes to DONE with accepted = 1. override_valid drops the next cycle without waiting for ready.
- State DONE:
  - done = 1 and accepted is held.
  - Slot enables are cleared on entry, and char_ready = 0.
  - start re-enters FILL with a fresh run; done and accepted fall the next cycle.
- Wrap-around: head and tail are CC_ID_BITS-wide counters that wrap mod W. When count = W the window is full, and load is blocked until a retire.
- Simultaneous retire and load eligibility: retire wins; the load proceeds on a later cycle.
- The guard prevents retiring a slot before the mesh's elaborating_chars reflects the injected PC.
- new_char never pulses two cycles in a row; at most one window change happens per cycle.
- Reset asserted mid-run: all state is abandoned at once, and override_valid drops asynchronously.

Test Plan:
1. W=2. Stream "ab" then terminator, with override_ready always 1 and elaborating_chars = 0 after the guard expires. Required: loads go to slots 0, 1, 0. override_data MSB sequence is 0, 1, 0. DONE is reached with accepted = 0 and chars_consumed = 3.
2. Assert any_bb_accept in FILL after the 2nd load. Required: next cycle done = 1, accepted = 1, and char_ready stays 0 thereafter.
3. Hold elaborating_chars = 2'b11 with 4 characters pending. Required: count stalls at 2 and char_ready = 0. Releasing bit 0 only: slot 0 retires, then the 3rd character loads into slot 0.
4. Hold override_ready = 0 for 5 cycles in INJECT. Required: override_valid and override_data stay stable, no new_char is pulsed, and no load occurs.
5. Assert rst during INJECT. Required: override_valid = 0 immediately, state returns to IDLE, and all outputs are 0.
6. Pulse start during FILL. Required: it is ignored. After done, a start pulse clears done and accepted and restarts with chars_consumed = 0.
